// File: rtl/a25_cache_pkg.sv
// Shared definitions for the cache maintenance block: FSM encoding, the
// cacheable-region field position in the address, and default geometry.
package a25_cache_pkg;

    localparam logic MAINT_IDLE  = 1'b0;
    localparam logic MAINT_FLUSH = 1'b1;

    // Address bits selecting one of 32 2MB regions in the cacheable map.
    localparam int REGION_LSB = 21;
    localparam int REGION_MSB = 25;

    localparam int DEFAULT_CACHE_LINES = 256;
    localparam int DEFAULT_WAYS        = 4;

    typedef enum logic {
        ST_IDLE  = MAINT_IDLE,
        ST_FLUSH = MAINT_FLUSH
    } maint_state_t;

endpackage

// File: rtl/a25_cache_maint_if.sv
// Bus bundle between CP15/core, the cache maintenance block and the tag RAM.
// o_flush_count exists only when A25_CACHE_MAINT_STATS_EN is defined.
interface a25_cache_maint_if #(
    parameter int INDEX_W = 8,
    parameter int WAYS    = 4
);
    logic               i_core_stall;
    logic               i_cache_flush;
    logic               i_cache_enable;
    logic [31:0]        i_cacheable_area;
    logic [31:0]        i_address;
    logic               i_address_valid;
    logic               o_cacheable;
    logic               o_stall;
    logic               o_tag_wr;
    logic [INDEX_W-1:0] o_tag_index;
    logic [WAYS-1:0]    o_tag_way_mask;
    logic               o_flush_done;
`ifdef A25_CACHE_MAINT_STATS_EN
    logic [15:0]        o_flush_count;
`endif

    modport master (
        output i_core_stall, i_cache_flush, i_cache_enable,
        output i_cacheable_area, i_address, i_address_valid,
        input  o_cacheable, o_stall, o_tag_wr, o_tag_index,
        input  o_tag_way_mask, o_flush_done
`ifdef A25_CACHE_MAINT_STATS_EN
        , input o_flush_count
`endif
    );

    modport slave (
        input  i_core_stall, i_cache_flush, i_cache_enable,
        input  i_cacheable_area, i_address, i_address_valid,
        output o_cacheable, o_stall, o_tag_wr, o_tag_index,
        output o_tag_way_mask, o_flush_done
`ifdef A25_CACHE_MAINT_STATS_EN
        , output o_flush_count
`endif
    );

endinterface

// File: rtl/a25_cache_maint.sv
// Whole-cache tag invalidation sequencer (power-on walk + CP15 flushes) and
// registered cacheable qualifier. Optional flush counter: A25_CACHE_MAINT_STATS_EN.
module a25_cache_maint
    import a25_cache_pkg::*;
#(
    parameter int  CACHE_LINES = DEFAULT_CACHE_LINES,
    parameter int  WAYS        = DEFAULT_WAYS,
    localparam int INDEX_W     = $clog2(CACHE_LINES)
) (
    input  logic              clk,
    input  logic              reset,
    a25_cache_maint_if.slave  bus
);

    maint_state_t       state_reg, state_next;
    logic [INDEX_W-1:0] index_reg, index_next;
    logic               pending_reg, pending_next;
    logic               enable_d1_reg;
    logic               cacheable_reg, cacheable_next;
    logic               flush_done;
    logic               trigger;
    logic               last_index;
    logic               tag_wr;
    logic [WAYS-1:0]    way_mask;
    logic               unused_addr_bits;

`ifdef A25_CACHE_MAINT_STATS_EN
    logic [15:0]        flush_count_reg, flush_count_next;
`endif

    assign trigger    = bus.i_cache_flush | (enable_d1_reg & ~bus.i_cache_enable);
    assign last_index = (index_reg == INDEX_W'(CACHE_LINES - 1));

    always_comb begin
        state_next     = state_reg;
        index_next     = index_reg;
        pending_next   = pending_reg;
        flush_done     = 1'b0;
        cacheable_next = cacheable_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (trigger) begin
                    state_next   = ST_FLUSH;
                    index_next   = '0;
                    pending_next = 1'b0;
                end
            end
            ST_FLUSH: begin
                if (last_index) begin
                    index_next   = '0;
                    pending_next = 1'b0;
                    // A trigger on the final index is treated as already pending.
                    if (!(pending_reg || trigger)) begin
                        state_next = ST_IDLE;
                        flush_done = 1'b1;
                    end
                end else begin
                    index_next = index_reg + INDEX_W'(1);
                    if (trigger) begin
                        pending_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (bus.i_address_valid && !bus.i_core_stall) begin
            cacheable_next = bus.i_cache_enable
                           & bus.i_cacheable_area[bus.i_address[REGION_MSB:REGION_LSB]]
                           & (state_reg == ST_IDLE);
        end
    end

`ifdef A25_CACHE_MAINT_STATS_EN
    always_comb begin
        flush_count_next = flush_count_reg;
        if (flush_done && (flush_count_reg != 16'hFFFF)) begin
            flush_count_next = flush_count_reg + 16'd1;
        end
    end
`endif

    // Reset parks the FSM in FLUSH at index 0 so the power-on walk runs on release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_FLUSH;
            index_reg       <= '0;
            pending_reg     <= 1'b0;
            enable_d1_reg   <= 1'b0;
            cacheable_reg   <= 1'b0;
`ifdef A25_CACHE_MAINT_STATS_EN
            flush_count_reg <= 16'd0;
`endif
        end else begin
            state_reg       <= state_next;
            index_reg       <= index_next;
            pending_reg     <= pending_next;
            enable_d1_reg   <= bus.i_cache_enable;
            cacheable_reg   <= cacheable_next;
`ifdef A25_CACHE_MAINT_STATS_EN
            flush_count_reg <= flush_count_next;
`endif
        end
    end

    assign tag_wr = (state_reg == ST_FLUSH);

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        assign way_mask[gi] = tag_wr;
    end

    assign bus.o_stall        = tag_wr;
    assign bus.o_tag_wr       = tag_wr;
    assign bus.o_tag_index    = index_reg;
    assign bus.o_tag_way_mask = way_mask;
    assign bus.o_flush_done   = flush_done;
    assign bus.o_cacheable    = cacheable_reg;
`ifdef A25_CACHE_MAINT_STATS_EN
    assign bus.o_flush_count  = flush_count_reg;
`endif

    // The region map wraps every 64MB; the remaining address bits are not decoded.
    assign unused_addr_bits = ^{bus.i_address[31:REGION_MSB+1], bus.i_address[REGION_LSB-1:0]};

endmodule

// File: tb/tb_a25_cache_maint.sv
// Directed bench for a25_cache_maint: walks, triggers, cacheable decode and
// mid-walk reset, checked against a scoreboard queue of expected values.
module tb_a25_cache_maint;

    localparam int LINES = 256;
    localparam int WAYS  = 4;
    localparam int IW    = 8;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];
    logic cach_model = 1'b0;

    a25_cache_maint_if #(.INDEX_W(IW), .WAYS(WAYS)) bus ();

    a25_cache_maint #(.CACHE_LINES(LINES), .WAYS(WAYS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] c_addr  [7] = '{32'h0040_0000, 32'h0020_0000, 32'h0440_0000,
                                 32'h0020_0000, 32'h0020_0000, 32'h0020_0000,
                                 32'hFC40_0000};
    logic        c_valid [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        c_stall [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_walk();
        for (int i = 0; i < LINES; i++) exp_q.push_back(i);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_stall"}, 32'(bus.o_stall), 32'd1);
        chk({tag, "_tag_wr"}, 32'(bus.o_tag_wr), 32'd1);
        chk({tag, "_index"}, 32'(bus.o_tag_index), 32'd0);
        chk({tag, "_mask"}, 32'(bus.o_tag_way_mask), 32'hF);
        chk({tag, "_cacheable"}, 32'(bus.o_cacheable), 32'd0);
        chk({tag, "_done"}, 32'(bus.o_flush_done), 32'd0);
`ifdef A25_CACHE_MAINT_STATS_EN
        chk({tag, "_count"}, 32'(bus.o_flush_count), 32'd0);
`endif
    endtask

    // Entered at posedge+1 with the walk already visible on the outputs.
    task automatic observe_walk(input string tag, input int fa, input int fb,
                                input int exp_stall, input int exp_done);
        int stalls = 0;
        int dones  = 0;
        int budget = 0;
        int idx;
        while (budget < 3000) begin
            idx = int'(bus.o_tag_index);
            bus.i_cache_flush = bus.o_stall && (stalls < LINES) && (idx == fa || idx == fb);
            #1;
            if (bus.o_stall) begin
                if (exp_q.size() == 0) chk({tag, "_queue_underflow"}, 32'(stalls), 32'hFFFF_FFFF);
                else chk({tag, "_index"}, 32'(bus.o_tag_index), 32'(exp_q.pop_front()));
                chk({tag, "_mask"}, 32'(bus.o_tag_way_mask), 32'hF);
                chk({tag, "_tag_wr"}, 32'(bus.o_tag_wr), 32'd1);
                stalls++;
            end
            if (bus.o_flush_done) begin
                dones++;
                chk({tag, "_done_on_last"}, {31'(bus.o_tag_index), bus.o_stall}, {31'(LINES - 1), 1'b1});
            end
            if (!bus.o_stall && stalls > 0) break;
            step();
            budget++;
        end
        bus.i_cache_flush = 1'b0;
        chk({tag, "_budget"}, 32'(budget < 3000), 32'd1);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        chk({tag, "_done_pulses"}, 32'(dones), 32'(exp_done));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_stall_after"}, 32'(bus.o_stall), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset                 = 1'b0;
        bus.i_core_stall      = 1'b0;
        bus.i_cache_flush     = 1'b0;
        bus.i_cache_enable    = 1'b1;
        bus.i_cacheable_area  = 32'h0000_0004;
        bus.i_address         = 32'h0;
        bus.i_address_valid   = 1'b0;

        // Reset state and power-on walk
        #12;
        check_reset_values("rst");
        step();
        reset = 1'b1;
        push_walk();
        observe_walk("poweron", -1, -1, LINES, 1);

        // Cacheable decode with a bench-side model
        for (int i = 0; i < 7; i++) begin
            step();
            bus.i_address       = c_addr[i];
            bus.i_address_valid = c_valid[i];
            bus.i_core_stall    = c_stall[i];
            if (c_valid[i] && !c_stall[i])
                cach_model = bus.i_cache_enable && bus.i_cacheable_area[c_addr[i][25:21]];
            exp_q.push_back(int'(cach_model));
            step();
            bus.i_address_valid = 1'b0;
            bus.i_core_stall    = 1'b0;
            chk($sformatf("cacheable_%0d", i), 32'(bus.o_cacheable), 32'(exp_q.pop_front()));
        end

        // Idle flush pulse at cycle T
        step();
        bus.i_cache_flush = 1'b1;
        #1;
        chk("flush_idle_before", 32'(bus.o_stall), 32'd0);
        step();
        bus.i_cache_flush = 1'b0;
        push_walk();
        observe_walk("flush_idle", -1, -1, LINES, 1);

        // Triggers at index 100 and 255 collapse into a single restart
        step();
        bus.i_cache_flush = 1'b1;
        step();
        bus.i_cache_flush = 1'b0;
        push_walk();
        push_walk();
        observe_walk("restart", 100, 255, 2 * LINES, 1);

        // Falling edge of enable triggers; rising edge does not
        step();
        bus.i_cache_enable = 1'b0;
        #1;
        chk("en_fall_before", 32'(bus.o_stall), 32'd0);
        step();
        push_walk();
        observe_walk("en_fall", -1, -1, LINES, 1);
        step();
        bus.i_cache_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("en_rise_no_walk_%0d", i), 32'(bus.o_stall), 32'd0);
        end

        // Reset at index 50 of a walk
        step();
        bus.i_cache_flush   = 1'b1;
        bus.i_address       = 32'h0040_0000;
        bus.i_address_valid = 1'b1;
        step();
        bus.i_cache_flush = 1'b0;
        for (int k = 0; k < 300 && !(bus.o_stall && bus.o_tag_index == IW'(50)); k++) step();
        #1;
        chk("midreset_at_index", 32'(bus.o_tag_index), 32'd50);
        chk("cacheable_during_walk", 32'(bus.o_cacheable), 32'd0);
        bus.i_address_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("midreset");
        step();
        step();
        reset = 1'b1;
        push_walk();
        observe_walk("after_reset", -1, -1, LINES, 1);
`ifdef A25_CACHE_MAINT_STATS_EN
        chk("count_after_walk", 32'(bus.o_flush_count), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
